// File: rtl/crt_sync_gen_if.sv
// Raster timing bundle between the CRT timing generator (master) and the fetch/DAC stages (slave).
// pxclk/med_res flow into the generator; every other signal is a registered timing output.
interface crt_sync_gen_if;
  logic       pxclk;
  logic       med_res;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       blank;
  logic       hsync_n;
  logic       vsync_n;
  logic       csync_n;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pxclk, med_res,
    output hpos, vpos, blank, hsync_n, vsync_n, csync_n, line_start, frame_start
  );

  modport slave (
    output pxclk, med_res,
    input  hpos, vpos, blank, hsync_n, vsync_n, csync_n, line_start, frame_start
  );
endinterface

// File: rtl/crt_sync_gen.sv
// CRT raster counters and sync/blank decode; outputs registered from next-state counters, zero lag.
// No backpressure: pxclk=0 freezes all state. CRT_SYNC_SERRATION_EN selects serrated csync_n.
module crt_sync_gen #(
  parameter int H_ACTIVE = 384,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 37,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 15
) (
  input  logic           clk,
  input  logic           reset,
  crt_sync_gen_if.master crt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [8:0] V_LAST = 9'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FP);
  localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [8:0] vc_q, vc_d;
  logic       mode_q, mode_d;
  logic       blank_q, blank_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       csync_n_q, csync_n_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  logic [9:0] htot_cur;
  logic [9:0] ha_nxt;
  logic [9:0] hs_beg;
  logic [9:0] hs_end;
  logic       hs_act;
  logic       vs_act;

  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    mode_d        = mode_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    htot_cur      = mode_q ? 10'(2 * H_TOT) : 10'(H_TOT);

    if (crt.pxclk) begin
      if (hc_q == htot_cur - 10'd1) begin
        hc_d         = '0;
        line_start_d = 1'b1;
        if (vc_q == V_LAST) begin
          vc_d          = '0;
          frame_start_d = 1'b1;
          mode_d        = crt.med_res;
        end else begin
          vc_d = vc_q + 9'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end

    // Decode against the mode that will own the next position, so the first
    // line after a frame wrap already uses the newly sampled timing.
    ha_nxt = mode_d ? 10'(2 * H_ACTIVE)                   : 10'(H_ACTIVE);
    hs_beg = mode_d ? 10'(2 * (H_ACTIVE + H_FP))          : 10'(H_ACTIVE + H_FP);
    hs_end = mode_d ? 10'(2 * (H_ACTIVE + H_FP + H_SYNC)) : 10'(H_ACTIVE + H_FP + H_SYNC);
    hs_act = (hc_d >= hs_beg) && (hc_d < hs_end);
    vs_act = (vc_d >= VS_BEG) && (vc_d < VS_END);

    blank_d   = blank_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    csync_n_d = csync_n_q;
    if (crt.pxclk) begin
      blank_d   = (hc_d >= ha_nxt) || (vc_d >= V_ACT);
      hsync_n_d = ~hs_act;
      vsync_n_d = ~vs_act;
`ifdef CRT_SYNC_SERRATION_EN
      csync_n_d = ~(hs_act ^ vs_act);
`else
      csync_n_d = ~hs_act & ~vs_act;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      mode_q        <= 1'b0;
      blank_q       <= 1'b1;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      csync_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mode_q        <= mode_d;
      blank_q       <= blank_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      csync_n_q     <= csync_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign crt.hpos        = hc_q;
  assign crt.vpos        = vc_q;
  assign crt.blank       = blank_q;
  assign crt.hsync_n     = hsync_n_q;
  assign crt.vsync_n     = vsync_n_q;
  assign crt.csync_n     = csync_n_q;
  assign crt.line_start  = line_start_q;
  assign crt.frame_start = frame_start_q;

endmodule

// File: doc/crt_sync_gen.md
# crt_sync_gen

Raster timing generator for the CRT path. It sits directly downstream of the pixel-clock divider and advances horizontal and vertical counters on every `clk` where `pxclk` is high. It decodes those counters into sync, blanking, position and line/frame strobes for the video fetch and DAC stages. It covers low-res (7.3728 MHz effective, `pxclk` toggling) and med-res (14.7456 MHz, `pxclk` held high, horizontal timing doubled) at 15.72 kHz line rate and 60 Hz field rate.

## Interface
Parameters:
- `H_ACTIVE`, 384: active pixels per line (low-res units)
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 32: hsync width
- `H_BP`, 37: horizontal back porch (total 469)
- `V_ACTIVE`, 240: active lines
- `V_FP`, 4: vertical front porch, in lines
- `V_SYNC`, 3: vsync width, in lines
- `V_BP`, 15: vertical back porch (total 262)

Ports:
- `clk`  in  1  system clock, 14.7456 MHz
- `reset`  in  1  synchronous, active-high
- `pxclk`  in  1  pixel enable, sampled as a level; counters advance on each `clk` edge where it is 1
- `med_res`  in  1  1 = double every horizontal parameter; sampled only at frame wrap
- `hpos`  out  10  current horizontal count `hc`
- `vpos`  out  9  current vertical count `vc`
- `blank`  out  1  1 outside the active area
- `hsync_n`  out  1  active-low horizontal sync
- `vsync_n`  out  1  active-low vertical sync
- `csync_n`  out  1  composite sync (see Configuration)
- `line_start`  out  1  one-`clk` pulse when `hc` wraps to 0
- `frame_start`  out  1  one-`clk` pulse when `hc` and `vc` both wrap to 0

## Operation
- `reset` (synchronous, active-high) wins over everything else. It is honoured mid-line and mid-frame with no flush.
- Reset values:
  - `hc` = 0, `vc` = 0, active `mode` register = 0 (low-res)
  - `hpos` = 0, `vpos` = 0
  - `hsync_n` = 1, `vsync_n` = 1, `csync_n` = 1
  - `blank` = 1
  - `line_start` = 0, `frame_start` = 0
- Scale `k` = 2 when `mode` = 1, else 1. Effective values: `HA` = k·`H_ACTIVE`, `HFP` = k·`H_FP`, `HS` = k·`H_SYNC`, `HTOT` = k·(`H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP`). Vertical values are never scaled.
- Horizontal counter, on a `pxclk`=1 edge: if `hc` = `HTOT`−1, then `hc` ← 0 and `vc` advances; otherwise `hc` ← `hc`+1.
- Vertical counter: `vc` wraps from `VTOT`−1 to 0 only in the same edge as an `hc` wrap. That edge is the frame wrap.
- `mode` ← `med_res` only at the frame wrap. A `med_res` change mid-frame never alters the line in progress.
- Horizontal regions: active [0, `HA`), front porch [`HA`, `HA`+`HFP`), sync [`HA`+`HFP`, `HA`+`HFP`+`HS`), back porch up to `HTOT`−1. Vertical regions follow the same order using the `V_*` parameters.
- Decoding:
  - `blank` = 1 when `hc` ≥ `HA` or `vc` ≥ `V_ACTIVE`.
  - `hsync_n` = 0 in the horizontal sync region.
  - `vsync_n` = 0 for the whole of every line whose `vc` is in the vertical sync region.
- `hpos`/`vpos` are the raw counters. They are not clamped in blanking, so consumers gate them with `blank`.
- `pxclk` held 0: all counters and outputs freeze; `line_start`/`frame_start` stay 0.

## Timing
- All outputs are registered and decoded from next-state counter values. In the `clk` edge where `hc` changes, `hpos`, `blank` and the syncs update together, with zero lag relative to the counters.
- `line_start` = 1 for exactly the one `clk` following the edge that wrapped `hc`. It is 0 on every other `clk`, including non-enabled cycles.
- `frame_start` follows the same rule on the frame wrap, coincident with `line_start`.
- The first edge after `reset` deasserts with `pxclk`=1 moves `hc` to 1. No strobe is emitted for the reset-induced position 0,0.
- Low-res line period = 469 enables = 938 `clk`. Med-res line period = 938 enables = 938 `clk`. Line rate is identical in both modes.

## Configuration
- `CRT_SYNC_SERRATION_EN` defined: `csync_n` = XNOR of active-high hsync and vsync. Sync pulses invert during vsync lines, giving serrated composite sync.
- `CRT_SYNC_SERRATION_EN` undefined: `csync_n` = `hsync_n` AND `vsync_n`, giving plain composite sync.
- In both cases `csync_n` is registered with the other syncs and resets to 1.

## Test plan
- Reset, then toggle `pxclk`, `med_res`=0: `line_start` pulses every 938 `clk`; `frame_start` every 262 lines (245 756 `clk`); `blank` = 0 for `hc` 0..383 on lines 0..239.
- Low-res: `hsync_n` = 0 exactly for `hc` 400..431; `vsync_n` = 0 for `vc` 244..246, the full line each.
- Reach frame wrap with `med_res`=1 and `pxclk` held 1: next line has `HTOT` = 938, active region `hc` 0..767, `hsync_n` low for `hc` 800..863.
- Toggle `med_res` at `vc` = 100: the timing in use is unchanged until `frame_start`, then switches.
- Assert `reset` for one `clk` at `hc` = 300, `vc` = 50: next cycle all outputs equal their reset values; counting restarts from 0,0.
- Vsync line with the macro defined: `csync_n` = 1 during `hc` 400..431 and 0 elsewhere on that line. With the macro undefined: `csync_n` = 0 for the entire line.
